// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
// Shared constants and types for the USB receive bit-recovery front end.
//   DEF_CLKS_PER_BIT  : system clocks per USB bit period (>= 4)
//   DEF_SAMPLE_POINT  : clk_cnt value at which the line is sampled
//   DEF_BITS_PER_BYTE : decoded data bits per byte_received pulse
//   DEF_STUFF_LIMIT   : consecutive decoded 1s after which a stuffed 0 follows
//   line_state_t      : differential line state encoded as {dp, dm}
package usb_rx_pkg;

  localparam int DEF_CLKS_PER_BIT  = 8;
  localparam int DEF_SAMPLE_POINT  = 3;
  localparam int DEF_BITS_PER_BYTE = 8;
  localparam int DEF_STUFF_LIMIT   = 6;

  // Encoding is {dp, dm} so a decode is a plain cast.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_state_t;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer_if.sv
// usb_rx_bit_timer_if
// Groups the line inputs, the timer enable and the decoded-bit outputs of the
// USB receive bit timer.
//   d_plus, d_minus : raw bus lines, asynchronous to clk
//   enable_timer    : high while the control unit expects packet traffic
//   shift_enable    : one-cycle strobe, serial_in valid while it is high
//   serial_in       : decoded data bit
//   byte_received   : one-cycle pulse after the last shift of a byte
//   eop             : one-cycle pulse, SE0 seen at a sample point
//   stuff_err       : one-cycle pulse, 1 seen where a stuffed 0 was required
// Handshake: shift_enable is a valid strobe with no ready/back-pressure; the
// consumer must accept serial_in in every cycle shift_enable is high, and
// serial_in carries no meaning in any other cycle.
// Modports: master = bit timer, slave = downstream shift register / control.
interface usb_rx_bit_timer_if;

  logic d_plus;
  logic d_minus;
  logic enable_timer;
  logic shift_enable;
  logic serial_in;
  logic byte_received;
  logic eop;
  logic stuff_err;

  modport master (
    input  d_plus, d_minus, enable_timer,
    output shift_enable, serial_in, byte_received, eop, stuff_err
  );

  modport slave (
    output d_plus, d_minus, enable_timer,
    input  shift_enable, serial_in, byte_received, eop, stuff_err
  );

endinterface

// File: rtl/usb_rx_sync_edge.sv
// usb_rx_sync_edge
// Two-flop synchroniser for D+ and D-, plus a transition detector on the
// synchronised D+ line.
//   clk, n_rst      : clock, asynchronous active-low reset
//   d_plus, d_minus : raw asynchronous lines
//   dp_s, dm_s      : second-stage synchronised lines
//   dp_edge         : dp_s differs from its value one cycle earlier
// RST_DP / RST_DM set the reset level of each line's flops (idle J = 1/0).
module usb_rx_sync_edge #(
  parameter logic RST_DP = 1'b1,
  parameter logic RST_DM = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic d_minus,
  output logic dp_s,
  output logic dm_s,
  output logic dp_edge
);

  logic dp_meta;
  logic dm_meta;
  logic dp_prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta <= RST_DP;
      dp_s    <= RST_DP;
      dp_prev <= RST_DP;
      dm_meta <= RST_DM;
      dm_s    <= RST_DM;
    end else begin
      dp_meta <= d_plus;
      dp_s    <= dp_meta;
      dp_prev <= dp_s;
      dm_meta <= d_minus;
      dm_s    <= dm_meta;
    end
  end

  assign dp_edge = dp_s ^ dp_prev;

endmodule

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer
// USB receive bit recovery: synchronises D+/D-, recovers bit timing from D+
// transitions, NRZI-decodes, removes stuffed bits and drives the downstream
// serial-to-parallel shift register.
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : usb_rx_bit_timer_if.master (lines, enable, decoded outputs)
// Optional feature macro USB_RX_STUFF_ERR_EN: when defined, a 1 sampled where
// a stuffed 0 was required raises stuff_err and is dropped; when undefined,
// stuff_err is tied 0 and such a 1 is shifted as data with ones_cnt
// saturating at STUFF_LIMIT.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = DEF_SAMPLE_POINT,
  parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE,
  parameter int STUFF_LIMIT   = DEF_STUFF_LIMIT
) (
  input  logic                clk,
  input  logic                n_rst,
  usb_rx_bit_timer_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int BW = $clog2(BITS_PER_BYTE);

  localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);
  localparam logic [OW-1:0] STUFF_CNT  = OW'(STUFF_LIMIT);
  localparam logic [BW-1:0] BIT_MAX    = BW'(BITS_PER_BYTE - 1);

  logic          dp_s;
  logic          dm_s;
  logic          dp_edge;

  logic [CW-1:0] clk_cnt;
  logic [OW-1:0] ones_cnt;
  logic [BW-1:0] bit_cnt;
  logic          prev_level;

  logic          shift_enable_q;
  logic          serial_in_q;
  logic          byte_pending;
  logic          byte_received_q;
  logic          eop_q;

  logic          sample;
  logic          se0;
  logic          nrzi_bit;
  logic          at_limit;
  logic          discard;
  logic          stuff_hit;
  logic [OW-1:0] ones_inc;

  usb_rx_sync_edge #(
    .RST_DP (1'b1),
    .RST_DM (1'b0)
  ) u_sync_edge (
    .clk     (clk),
    .n_rst   (n_rst),
    .d_plus  (bus.d_plus),
    .d_minus (bus.d_minus),
    .dp_s    (dp_s),
    .dm_s    (dm_s),
    .dp_edge (dp_edge)
  );

  always_comb begin
    sample   = bus.enable_timer && (clk_cnt == SAMPLE_CNT);
    se0      = (decode_line(dp_s, dm_s) == LINE_SE0);
    // NRZI: no change from the previous sampled level decodes as 1.
    nrzi_bit = (dp_s == prev_level);
    at_limit = (ones_cnt == STUFF_CNT);
    // A 0 after STUFF_LIMIT ones is always the stuffed bit.
    discard  = at_limit && !nrzi_bit;
    ones_inc = at_limit ? ones_cnt : ones_cnt + 1'b1;
  end

`ifdef USB_RX_STUFF_ERR_EN
  assign stuff_hit = at_limit && nrzi_bit;
`else
  assign stuff_hit = 1'b0;
`endif

`ifdef USB_RX_STUFF_ERR_EN
  logic stuff_err_q;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt         <= '0;
      ones_cnt        <= '0;
      bit_cnt         <= '0;
      prev_level      <= 1'b1;
      shift_enable_q  <= 1'b0;
      serial_in_q     <= 1'b1;
      byte_pending    <= 1'b0;
      byte_received_q <= 1'b0;
      eop_q           <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
      stuff_err_q     <= 1'b0;
`endif
    end else begin
      shift_enable_q  <= 1'b0;
      eop_q           <= 1'b0;
      byte_pending    <= 1'b0;
      // Delayed one cycle so the shift register already holds the last bit.
      byte_received_q <= byte_pending;
`ifdef USB_RX_STUFF_ERR_EN
      stuff_err_q     <= 1'b0;
`endif
      if (!bus.enable_timer) begin
        clk_cnt    <= '0;
        ones_cnt   <= '0;
        bit_cnt    <= '0;
        prev_level <= 1'b1;
      end else begin
        // Every D+ transition re-aligns the bit phase.
        if (dp_edge) begin
          clk_cnt <= '0;
        end else if (clk_cnt == CNT_MAX) begin
          clk_cnt <= '0;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end

        if (sample) begin
          if (se0) begin
            eop_q      <= 1'b1;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            prev_level <= 1'b1;
          end else begin
            prev_level <= dp_s;
`ifdef USB_RX_STUFF_ERR_EN
            stuff_err_q <= stuff_hit;
`endif
            if (discard || stuff_hit) begin
              ones_cnt <= '0;
            end else begin
              shift_enable_q <= 1'b1;
              serial_in_q    <= nrzi_bit;
              ones_cnt       <= nrzi_bit ? ones_inc : '0;
              if (bit_cnt == BIT_MAX) begin
                bit_cnt      <= '0;
                byte_pending <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign bus.shift_enable  = shift_enable_q;
  assign bus.serial_in     = serial_in_q;
  assign bus.byte_received = byte_received_q;
  assign bus.eop           = eop_q;
`ifdef USB_RX_STUFF_ERR_EN
  assign bus.stuff_err     = stuff_err_q;
`else
  assign bus.stuff_err     = 1'b0;
`endif

endmodule
